// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, keeps one request in flight to a variable-latency
// instruction memory and presents each fetched word to IF/ID. Build option: FETCH_ALIGN_CHECK_EN.
module if_fetch_unit #(
  parameter int                 WIDTH_I  = 32,
  parameter logic [WIDTH_I-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_ctrl,
  input  logic               flush_ctrl,
  input  logic [WIDTH_I-1:0] redirect_pc,
  output logic               imem_req,
  output logic [WIDTH_I-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [WIDTH_I-1:0] imem_rdata,
  output logic [WIDTH_I-1:0] memi_out,
  output logic [WIDTH_I-1:0] pc_next,
  output logic               fetch_valid,
  output logic               fetch_busy,
  output logic               misalign_err
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  state_t               state_reg;
  logic [WIDTH_I-1:0]   pc_reg;
  logic [WIDTH_I-1:0]   ibuf_reg;
  logic                 fetch_valid_reg;

  logic [WIDTH_I-1:0]   pc_inc;
  logic [WIDTH_I-1:0]   redirect_aligned;
  logic                 advance;

  assign pc_inc           = pc_reg + WIDTH_I'(4);
  assign redirect_aligned = redirect_pc & ~WIDTH_I'(3);
  assign advance          = (state_reg == S_PRESENT) && !stall_ctrl && !flush_ctrl;

  // A FETCH-state request goes out even when a flush arrives; DROP then swallows its response.
  assign imem_req  = !rst && ((state_reg == S_FETCH) || advance);
  assign imem_addr = (state_reg == S_PRESENT) ? pc_inc : pc_reg;

  assign fetch_valid = fetch_valid_reg;
  assign fetch_busy  = !fetch_valid_reg;
  assign memi_out    = fetch_valid_reg ? ibuf_reg : '0;
  assign pc_next     = fetch_valid_reg ? pc_inc   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_FETCH;
      pc_reg          <= RESET_PC;
      ibuf_reg        <= '0;
      fetch_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (flush_ctrl) begin
            pc_reg    <= redirect_aligned;
            state_reg <= S_DROP;
          end else begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_ctrl) begin
            pc_reg    <= redirect_aligned;
            state_reg <= imem_rvalid ? S_FETCH : S_DROP;
          end else if (imem_rvalid) begin
            ibuf_reg        <= imem_rdata;
            fetch_valid_reg <= 1'b1;
            state_reg       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (flush_ctrl) begin
            pc_reg          <= redirect_aligned;
            fetch_valid_reg <= 1'b0;
            state_reg       <= S_FETCH;
          end else if (!stall_ctrl) begin
            pc_reg          <= pc_inc;
            fetch_valid_reg <= 1'b0;
            state_reg       <= S_WAIT;
          end
        end
        default: begin
          // S_DROP: the stale response is discarded; a newer redirect simply overwrites pc.
          if (flush_ctrl) begin
            pc_reg <= redirect_aligned;
          end
          if (imem_rvalid) begin
            state_reg <= S_FETCH;
          end
        end
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else if (flush_ctrl && (redirect_pc[1:0] != 2'b00)) begin
      misalign_reg <= 1'b1;
    end
  end

  assign misalign_err = misalign_reg;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

- Instruction-fetch stage of the pipeline CPU, and the producer side of the IF/ID pipeline register.
- Holds the PC and issues one outstanding request at a time to a variable-latency instruction memory.
- Presents each fetched word with its PC+4 to IF/ID.
- Obeys `stall_ctrl` and `flush_ctrl` from the hazard unit; on a flush it redirects and discards stale responses.

## Interface
- `WIDTH_I`, 32: instruction, address and PC width.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_ctrl`  in  1  hold the presented instruction; do not advance the PC.
- `flush_ctrl`  in  1  redirect to `redirect_pc`; has priority over `stall_ctrl`.
- `redirect_pc`  in  WIDTH_I  branch or jump target, sampled when `flush_ctrl`=1.
- `imem_req`  out  1  request strobe; the memory accepts it in the same cycle.
- `imem_addr`  out  WIDTH_I  request address.
- `imem_rvalid`  in  1  response valid, exactly one per request, arriving 1 or more cycles after it.
- `imem_rdata`  in  WIDTH_I  response word.
- `memi_out`  out  WIDTH_I  instruction to IF/ID; 0 (bubble) when `fetch_valid`=0.
- `pc_next`  out  WIDTH_I  PC+4 of the presented instruction; 0 when `fetch_valid`=0.
- `fetch_valid`  out  1  `memi_out`/`pc_next` hold a real instruction.
- `fetch_busy`  out  1  equals ~`fetch_valid`; goes to the hazard unit.
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Registers:
  - `pc`: address of the current or pending fetch.
  - `ibuf`: WIDTH_I instruction buffer.
  - state: FETCH, WAIT, PRESENT, DROP.
- FETCH:
  - Drive `imem_req`=1, `imem_addr`=`pc`.
  - Next state WAIT, or DROP if `flush_ctrl`=1.
- WAIT:
  - If `imem_rvalid`=1: capture `ibuf`<=`imem_rdata` and go to PRESENT.
  - If `imem_rvalid`=0: stay in WAIT.
- PRESENT: `fetch_valid`=1, `memi_out`=`ibuf`, `pc_next`=`pc`+4.
  - `stall_ctrl`=1: stay in PRESENT; outputs stay stable.
  - `stall_ctrl`=0: `pc`<=`pc`+4, drive `imem_req`=1 with `imem_addr`=`pc`+4 in the same cycle, go to WAIT (back-to-back fetch).
- DROP:
  - Wait for `imem_rvalid`, discard the response, go to FETCH.
  - `ibuf` is not written.
- Flush, any state: `pc`<=`redirect_pc` (with bits [1:0] cleared).
  - FETCH → DROP.
  - WAIT with no `imem_rvalid` → DROP.
  - WAIT with `imem_rvalid` in the same cycle → response discarded, go to FETCH.
  - PRESENT → FETCH, with no request issued that cycle.
  - DROP → stays DROP; the newest `redirect_pc` wins.
- PC arithmetic is modulo 2^WIDTH_I: `pc`=FFFF_FFFC advances to 0.
- `imem_rvalid` in FETCH or PRESENT is a protocol violation: ignored, no state change.

## Timing
- Reset values:
  - state FETCH, `pc`=RESET_PC, `ibuf`=0, `misalign_err`=0.
  - Outputs: `memi_out`=0, `pc_next`=0, `fetch_valid`=0, `fetch_busy`=1.
  - `imem_req`=0 during the reset cycle.
- The first request is issued in the first cycle after reset deasserts.
- Reset mid-WAIT or mid-DROP returns the block to FETCH. The memory shares `rst` and cancels its outstanding response.
- Latency with memory latency L (rvalid L cycles after req):
  - Request in cycle t, rvalid in t+L, PRESENT in t+L+1.
  - IF/ID captures at the end of cycle t+L+1.
- Peak throughput with L=1 is one instruction per 2 cycles.
- All outputs are decoded from registered state and `ibuf`, so none depend combinationally on `imem_rdata`.
- `imem_req` depends combinationally only on state, `stall_ctrl` and `flush_ctrl`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A flush with `redirect_pc`[1:0]≠0 sets `misalign_err` to 1.
  - `misalign_err` stays 1 until reset.
  - The PC is still loaded with bits [1:0] cleared.
- Not defined: `redirect_pc`[1:0] is silently cleared and `misalign_err` is tied to 0.

## Test plan
- Reset release, RESET_PC=0, L=1, `imem_rdata`=0x0000_0013:
  - req addr 0 in cycle 1, PRESENT in cycle 3 with `memi_out`=0x13, `pc_next`=4.
  - Next req addr 4 in cycle 3.
- Stall for 3 cycles in PRESENT: `memi_out`/`pc_next` stay constant, `imem_req`=0, and the PC advances only after `stall_ctrl` falls.
- Flush with `redirect_pc`=0x100 during WAIT with L=4:
  - The old response is discarded and never appears on `memi_out`.
  - Next req addr 0x100.
- Flush and `imem_rvalid` in the same WAIT cycle: response dropped, FETCH issues addr 0x100 in the following cycle.
- `pc`=0xFFFF_FFFC with no stall: `pc_next`=0, next req addr 0.
- With `FETCH_ALIGN_CHECK_EN`, flush to 0x102: req addr 0x100 and `misalign_err`=1 until `rst`. Without the macro, req addr 0x100 and `misalign_err`=0.
